// File: rtl/type_buffer_pkg.sv
// Shared constants and state encoding for the typed-text producer.
package type_buffer_pkg;

  localparam int N_CHARS    = 25;
  localparam int CW         = 5;
  localparam int KW_DEFAULT = 8;
  localparam int TW         = N_CHARS * CW;

  localparam logic [CW-1:0] EMPTY_CODE = '0;

  typedef enum logic [1:0] {
    IDLE,
    TYPING,
    DONE
  } state_t;

endpackage

// File: rtl/slot_writer.sv
// Combinational next value of the typed/correct vectors for a single-slot write or clear.
module slot_writer
  import type_buffer_pkg::*;
(
  input  logic [TW-1:0]      type_cur,
  input  logic [N_CHARS-1:0] correct_cur,
  input  logic [4:0]         idx,
  input  logic [CW-1:0]      code,
  input  logic [TW-1:0]      tgt,
  input  logic               wr_en,
  input  logic               clr_en,
  output logic [TW-1:0]      type_next,
  output logic [N_CHARS-1:0] correct_next,
  output logic               match
);

  always_comb begin
    type_next    = type_cur;
    correct_next = correct_cur;
    match        = 1'b0;
    for (int i = 0; i < N_CHARS; i++) begin
      if (int'(idx) == i) begin
        match = (code == tgt[i*CW +: CW]);
        if (wr_en) begin
          type_next[i*CW +: CW] = code;
          correct_next[i]       = match;
        end else if (clr_en) begin
          type_next[i*CW +: CW] = EMPTY_CODE;
          correct_next[i]       = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/type_buffer.sv
// Typed-character buffer: accepts key events, grades each slot against the target
// sentence at write time and keeps fill count plus saturating keystroke/error counters.
module type_buffer
  import type_buffer_pkg::*;
#(
  parameter int KW = KW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TW-1:0]      tgt,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [CW-1:0]      key_code,
  input  logic               key_bs,
  // 'type' is a reserved word, so the typed-character vector is called typed
  output logic [TW-1:0]      typed,
  output logic [N_CHARS-1:0] correct,
  output logic [4:0]         tot,
  output logic [KW-1:0]      keys,
  output logic [KW-1:0]      errs,
  output logic               done
);

  state_t               state;
  logic                 accept;
  logic                 wr_en;
  logic                 clr_en;
  logic                 match;
  logic [4:0]           idx;
  logic [TW-1:0]        type_next;
  logic [N_CHARS-1:0]   correct_next;

  assign key_ready = (state == TYPING) && !start;
  assign accept    = key_valid && key_ready;
  assign wr_en     = accept && !key_bs && (key_code != EMPTY_CODE) && (tot < 5'(N_CHARS));
  assign clr_en    = accept && key_bs && (tot != 5'd0);
  assign idx       = key_bs ? tot - 5'd1 : tot;

  slot_writer u_slot_writer (
    .type_cur     (typed),
    .correct_cur  (correct),
    .idx          (idx),
    .code         (key_code),
    .tgt          (tgt),
    .wr_en        (wr_en),
    .clr_en       (clr_en),
    .type_next    (type_next),
    .correct_next (correct_next),
    .match        (match)
  );

  // Reset beats start; start beats any key event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      typed   <= '0;
      correct <= '0;
      tot     <= '0;
      keys    <= '0;
      errs    <= '0;
      done    <= 1'b0;
    end else if (start) begin
      state   <= TYPING;
      typed   <= '0;
      correct <= '0;
      tot     <= '0;
      keys    <= '0;
      errs    <= '0;
      done    <= 1'b0;
    end else begin
      if (wr_en || clr_en) begin
        typed   <= type_next;
        correct <= correct_next;
      end
      if (wr_en) begin
        tot <= tot + 5'd1;
        if (keys != '1) keys <= keys + KW'(1);
        if (!match && errs != '1) errs <= errs + KW'(1);
        if (tot == 5'(N_CHARS - 1)) begin
          state <= DONE;
          done  <= 1'b1;
        end
      end else if (clr_en) begin
        tot <= tot - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_type_buffer.sv
// Scoreboard bench for type_buffer: a queue-based model predicts the outputs after each
// reset/start/accepted event; a negedge monitor pops and compares.
module tb_type_buffer;
  import type_buffer_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [TW-1:0]      tgt;
  logic               key_valid;
  logic               key_code_bs;
  logic [CW-1:0]      key_code;
  logic               key_ready;
  logic [TW-1:0]      typed;
  logic [N_CHARS-1:0] correct;
  logic [4:0]         tot;
  logic [7:0]         keys;
  logic [7:0]         errs;
  logic               done;

  logic               key_ready3;
  logic [TW-1:0]      typed3;
  logic [N_CHARS-1:0] correct3;
  logic [4:0]         tot3;
  logic [2:0]         keys3;
  logic [2:0]         errs3;
  logic               done3;

  type_buffer #(.KW(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tgt(tgt),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code), .key_bs(key_code_bs),
    .typed(typed), .correct(correct), .tot(tot), .keys(keys), .errs(errs), .done(done)
  );

  type_buffer #(.KW(3)) u_sat (
    .clk(clk), .rst(rst), .start(start), .tgt(tgt),
    .key_valid(key_valid), .key_ready(key_ready3), .key_code(key_code), .key_bs(key_code_bs),
    .typed(typed3), .correct(correct3), .tot(tot3), .keys(keys3), .errs(errs3), .done(done3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]      typed;
    logic [N_CHARS-1:0] correct;
    logic [4:0]         tot;
    logic [7:0]         keys;
    logic [7:0]         errs;
    logic [2:0]         keys3;
    logic [2:0]         errs3;
    logic               done;
  } snap_t;

  snap_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;

  // Reference model: phase 0 idle, 1 typing, 2 done; line held as a queue of codes.
  int            m_phase = 0;
  int            m_codes[$];
  bit            m_grades[$];
  int            m_keys = 0;
  int            m_errs = 0;
  logic          exp_ready = 1'b0;
  logic [TW-1:0] next_tgt;

  function automatic logic [CW-1:0] slot_of(logic [TW-1:0] t, int i);
    return t[i*CW +: CW];
  endfunction

  function automatic logic [TW-1:0] rand_tgt();
    logic [TW-1:0] t;
    for (int i = 0; i < N_CHARS; i++) t[i*CW +: CW] = CW'($urandom_range(1, 31));
    return t;
  endfunction

  function automatic logic [CW-1:0] wrong_code(logic [CW-1:0] want);
    return (want == 5'd1) ? 5'd2 : 5'd1;
  endfunction

  function automatic snap_t model_snapshot();
    snap_t s;
    s.typed   = '0;
    s.correct = '0;
    for (int i = 0; i < m_codes.size(); i++) begin
      s.typed[i*CW +: CW] = CW'(m_codes[i]);
      s.correct[i]        = m_grades[i];
    end
    s.tot   = 5'(m_codes.size());
    s.keys  = 8'((m_keys > 255) ? 255 : m_keys);
    s.errs  = 8'((m_errs > 255) ? 255 : m_errs);
    s.keys3 = 3'((m_keys > 7) ? 7 : m_keys);
    s.errs3 = 3'((m_errs > 7) ? 7 : m_errs);
    s.done  = (m_phase == 2);
    return s;
  endfunction

  function automatic void model_clear();
    m_codes.delete();
    m_grades.delete();
    m_keys = 0;
    m_errs = 0;
  endfunction

  task automatic applyStimulus(input logic r, input logic st, input logic v,
                               input logic bs, input logic [CW-1:0] code);
    bit acc;
    @(posedge clk);
    #1;
    rst         = r;
    start       = st;
    key_valid   = v;
    key_code_bs = bs;
    key_code    = code;
    tgt         = next_tgt;
    exp_ready   = (m_phase == 1) && !st;
    acc         = v && exp_ready && !r;
    if (r) begin
      model_clear();
      m_phase = 0;
    end else if (st) begin
      model_clear();
      m_phase = 1;
    end else if (acc) begin
      if (bs) begin
        if (m_codes.size() > 0) begin
          void'(m_codes.pop_back());
          void'(m_grades.pop_back());
        end
      end else if (code != 0 && m_codes.size() < N_CHARS) begin
        m_grades.push_back(code == slot_of(tgt, m_codes.size()));
        m_codes.push_back(int'(code));
        m_keys++;
        if (!m_grades[$]) m_errs++;
        if (m_codes.size() == N_CHARS) m_phase = 2;
      end
    end
    if (r || st || acc) exp_q.push_back(model_snapshot());
  endtask

  task automatic send_key(input logic bs, input logic [CW-1:0] code);
    applyStimulus(1'b0, 1'b0, 1'b1, bs, code);
  endtask

  task automatic cmp(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    snap_t s;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_update: got an accept, expected none at %0t", $time);
    end else begin
      s = exp_q.pop_front();
      cmp("typed",   TW'(typed),    TW'(s.typed));
      cmp("correct", TW'(correct),  TW'(s.correct));
      cmp("tot",     TW'(tot),      TW'(s.tot));
      cmp("keys",    TW'(keys),     TW'(s.keys));
      cmp("errs",    TW'(errs),     TW'(s.errs));
      cmp("done",    TW'(done),     TW'(s.done));
      cmp("keys_kw3", TW'(keys3),   TW'(s.keys3));
      cmp("errs_kw3", TW'(errs3),   TW'(s.errs3));
      cmp("tot_kw3",  TW'(tot3),    TW'(s.tot));
    end
  endtask

  // Monitor: an event seen at one negedge takes effect at the next posedge and is checked
  // at the following negedge.
  initial begin
    bit pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) checkOutput();
      cmp("key_ready", TW'(key_ready), TW'(exp_ready));
      cmp("key_ready_kw3", TW'(key_ready3), TW'(exp_ready));
      pending = rst || start || (key_valid && key_ready);
    end
  end

  initial begin
    logic [CW-1:0] c;
    int            bs_pct;
    rst         = 1'b1;
    start       = 1'b0;
    key_valid   = 1'b0;
    key_code_bs = 1'b0;
    key_code    = '0;
    next_tgt    = rand_tgt();
    tgt         = next_tgt;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] reset mid-round");
    applyStimulus(0, 1, 0, 0, 0);
    send_key(0, 5'd7);
    send_key(0, 5'd9);
    applyStimulus(1, 1, 1, 0, 5'd5);
    applyStimulus(0, 0, 0, 0, 0);
    next_tgt = rand_tgt();
    next_tgt[4:0] = 5'd3;
    next_tgt[9:5] = 5'd3;
    next_tgt[14:10] = 5'd4;
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send_key(0, 5'd3);

    $display("[TB] backspace");
    for (int i = 0; i < 4; i++) send_key(1, 5'd0);

    $display("[TB] fill the line");
    next_tgt = rand_tgt();
    for (int i = 0; i < N_CHARS; i++) send_key(0, slot_of(next_tgt, i));
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 5'd7);

    $display("[TB] start with key_valid, held event, zero code");
    applyStimulus(0, 1, 1, 0, 5'd9);
    for (int i = 0; i < 3; i++) send_key(0, 5'd9);
    send_key(0, 5'd0);

    $display("[TB] target change mid-round");
    applyStimulus(0, 1, 0, 0, 0);
    send_key(0, slot_of(next_tgt, 0));
    next_tgt[4:0] = wrong_code(slot_of(next_tgt, 0));
    send_key(0, slot_of(next_tgt, 1));
    send_key(0, 5'd1);

    $display("[TB] error saturation");
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      send_key(0, wrong_code(slot_of(next_tgt, m_codes.size())));
      if (k % 2 == 1) send_key(1, 5'd0);
    end

    $display("[TB] random rounds");
    for (int round = 0; round < 8; round++) begin
      next_tgt = rand_tgt();
      bs_pct   = (round % 2 == 0) ? 25 : 3;
      applyStimulus(0, 1, 0, 0, 0);
      for (int cyc = 0; cyc < 80; cyc++) begin
        if ($urandom_range(0, 99) < 50 && m_codes.size() < N_CHARS)
          c = slot_of(next_tgt, m_codes.size());
        else if ($urandom_range(0, 9) == 0)
          c = 5'd0;
        else
          c = CW'($urandom_range(1, 31));
        applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < bs_pct) ? 1'b1 : 1'b0,
                      c);
      end
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending updates, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
